flit_mux2: RTL and testbench

Two-input flit multiplexer with a registered output stage. It selects one of two router input ports (data, valid, virtual-channel ID) under a one-hot select and forwards it to a single output port one clock later. It sits in the router crossbar path and serves as the unit block for per-mux energy characterization. Optional activity counters expose output bit-toggle and flit statistics.

---
 rtl/flit_pkg.sv | 33 +++
 rtl/flit_mux2_if.sv | 31 +++
 rtl/flit_act_cnt.sv | 68 ++++++
 rtl/flit_mux2.sv | 83 ++++++++
 tb/tb_flit_mux2.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/flit_pkg.sv
// Shared flit definitions: type codes, default widths, type field position and select decode.
package flit_pkg;

  localparam int DATAW    = 66;
  localparam int VCHW     = 2;
  localparam int PORTW    = 5;
  localparam int CNTW     = 32;
  localparam int TYPE_MSB = DATAW - 1;
  localparam int TYPE_LSB = DATAW - 2;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_P0   = 2'b01,
    SRC_P1   = 2'b10
  } src_e;

  // Both-bits-set is treated as no selection, same as all-zero.
  function automatic src_e decode_sel(input logic [1:0] s);
    case (s)
      2'b01:   return SRC_P0;
      2'b10:   return SRC_P1;
      default: return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flit_mux2_if.sv
// Two input router ports, one-hot select and the registered output port of flit_mux2.
interface flit_mux2_if #(
  parameter int DATAW = flit_pkg::DATAW,
  parameter int VCHW  = flit_pkg::VCHW,
  parameter int PORTW = flit_pkg::PORTW
);
  logic [DATAW-1:0] idata_0;
  logic             ivalid_0;
  logic [VCHW-1:0]  ivch_0;
  logic [DATAW-1:0] idata_1;
  logic             ivalid_1;
  logic [VCHW-1:0]  ivch_1;
  logic [PORTW-1:0] sel;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [VCHW-1:0]  ovch;

  modport slave (
    input  idata_0, ivalid_0, ivch_0,
    input  idata_1, ivalid_1, ivch_1,
    input  sel,
    output odata, ovalid, ovch
  );

  modport master (
    output idata_0, ivalid_0, ivch_0,
    output idata_1, ivalid_1, ivch_1,
    output sel,
    input  odata, ovalid, ovch
  );
endinterface

// File: rtl/flit_act_cnt.sv
// Output activity counters: saturating odata bit-toggle count and valid-flit count.
module flit_act_cnt #(
  parameter int DATAW = flit_pkg::DATAW,
  parameter int CNTW  = flit_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             act_clr,
  input  logic             load,
  input  logic             flit_load,
  input  logic [DATAW-1:0] data_next,
  input  logic [DATAW-1:0] data_cur,
  output logic [CNTW-1:0]  act_toggles,
  output logic [CNTW-1:0]  act_flits
);
  localparam int PCW = $clog2(DATAW + 1);

  logic [DATAW-1:0] diff;
  logic [PCW-1:0]   pop;
  logic [CNTW:0]    tog_sum;
  logic [CNTW-1:0]  tog_reg, tog_next;
  logic [CNTW-1:0]  flit_reg, flit_next;

  genvar gi;
  generate
    for (gi = 0; gi < DATAW; gi++) begin : g_diff
      assign diff[gi] = data_next[gi] ^ data_cur[gi];
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATAW; i++) begin
      pop = pop + PCW'(diff[i]);
    end
  end

  // Extra carry bit detects overflow so the count pins at all-ones.
  always_comb begin
    tog_sum   = {1'b0, tog_reg} + (CNTW+1)'(pop);
    tog_next  = tog_reg;
    flit_next = flit_reg;
    if (act_clr) begin
      tog_next  = '0;
      flit_next = '0;
    end else begin
      if (load) begin
        tog_next = tog_sum[CNTW] ? {CNTW{1'b1}} : tog_sum[CNTW-1:0];
      end
      if (flit_load && !(&flit_reg)) begin
        flit_next = flit_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tog_reg  <= '0;
      flit_reg <= '0;
    end else begin
      tog_reg  <= tog_next;
      flit_reg <= flit_next;
    end
  end

  assign act_toggles = tog_reg;
  assign act_flits   = flit_reg;
endmodule

// File: rtl/flit_mux2.sv
// Two-input flit mux with registered output; one cycle latency, no backpressure.
// Define ACT_CNT_EN to add the act_clr/act_toggles/act_flits activity counters.
module flit_mux2 #(
  parameter int DATAW = flit_pkg::DATAW,
  parameter int VCHW  = flit_pkg::VCHW,
  parameter int PORTW = flit_pkg::PORTW,
  parameter int CNTW  = flit_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst_,
  flit_mux2_if.slave      bus
`ifdef ACT_CNT_EN
  ,
  input  logic            act_clr,
  output logic [CNTW-1:0] act_toggles,
  output logic [CNTW-1:0] act_flits
`endif
);
  flit_pkg::src_e   src;
  logic [DATAW-1:0] odata_reg, data_next;
  logic [VCHW-1:0]  ovch_reg, vch_next;
  logic             ovalid_reg, valid_next;
  logic             unused_sel;

  assign unused_sel = ^bus.sel[PORTW-1:2];

  // Data and VC follow the selected port even when its valid is low.
  always_comb begin
    src        = flit_pkg::decode_sel(bus.sel[1:0]);
    data_next  = odata_reg;
    vch_next   = ovch_reg;
    valid_next = 1'b0;
    case (src)
      flit_pkg::SRC_P0: begin
        data_next  = bus.idata_0;
        vch_next   = bus.ivch_0;
        valid_next = bus.ivalid_0;
      end
      flit_pkg::SRC_P1: begin
        data_next  = bus.idata_1;
        vch_next   = bus.ivch_1;
        valid_next = bus.ivalid_1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_reg  <= '0;
      ovch_reg   <= '0;
      ovalid_reg <= 1'b0;
    end else begin
      odata_reg  <= data_next;
      ovch_reg   <= vch_next;
      ovalid_reg <= valid_next;
    end
  end

  assign bus.odata  = odata_reg;
  assign bus.ovch   = ovch_reg;
  assign bus.ovalid = ovalid_reg;

`ifdef ACT_CNT_EN
  logic load;
  assign load = (src != flit_pkg::SRC_NONE);

  flit_act_cnt #(
    .DATAW (DATAW),
    .CNTW  (CNTW)
  ) u_act_cnt (
    .clk         (clk),
    .rst_        (rst_),
    .act_clr     (act_clr),
    .load        (load),
    .flit_load   (valid_next),
    .data_next   (data_next),
    .data_cur    (odata_reg),
    .act_toggles (act_toggles),
    .act_flits   (act_flits)
  );
`endif
endmodule

// File: tb/tb_flit_mux2.sv
// Scoreboard bench for flit_mux2: driver pushes expected outputs, monitor pops one per cycle.
module tb_flit_mux2;
  import flit_pkg::*;

  typedef struct {
    logic [DATAW-1:0] data;
    logic             valid;
    logic [VCHW-1:0]  vch;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_;
  logic act_clr;
  logic [CNTW-1:0] act_toggles;
  logic [CNTW-1:0] act_flits;

  int tests = 0;
  int fails = 0;
  int txn   = 0;
  exp_t sb[$];
  logic [DATAW-1:0] m_data;
  logic [VCHW-1:0]  m_vch;
  logic [DATAW-1:0] ones;

  flit_mux2_if bus ();

  always #5 clk = ~clk;

`ifdef ACT_CNT_EN
  flit_mux2 dut (.clk(clk), .rst_(rst_), .bus(bus),
                 .act_clr(act_clr), .act_toggles(act_toggles), .act_flits(act_flits));
`else
  flit_mux2 dut (.clk(clk), .rst_(rst_), .bus(bus));
  assign act_toggles = '0;
  assign act_flits   = '0;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ".odata"},  128'(bus.odata),  128'd0);
    check({name, ".ovalid"}, 128'(bus.ovalid), 128'd0);
    check({name, ".ovch"},   128'(bus.ovch),   128'd0);
`ifdef ACT_CNT_EN
    check({name, ".toggles"}, 128'(act_toggles), 128'd0);
    check({name, ".flits"},   128'(act_flits),   128'd0);
`endif
  endtask

  // One input vector per cycle; the model works out what the next edge must present.
  task automatic drive(input logic [PORTW-1:0] s,
                       input logic [DATAW-1:0] d0, input logic v0, input logic [VCHW-1:0] c0,
                       input logic [DATAW-1:0] d1, input logic v1, input logic [VCHW-1:0] c1,
                       input logic clr, input string tag);
    exp_t e;
    @(negedge clk);
    bus.sel = s;
    bus.idata_0 = d0; bus.ivalid_0 = v0; bus.ivch_0 = c0;
    bus.idata_1 = d1; bus.ivalid_1 = v1; bus.ivch_1 = c1;
    act_clr = clr;
    e.valid = 1'b0;
    case (s[1:0])
      2'b01: begin m_data = d0; m_vch = c0; e.valid = v0; end
      2'b10: begin m_data = d1; m_vch = c1; e.valid = v1; end
      default: ;
    endcase
    e.data = m_data;
    e.vch  = m_vch;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        check({e.tag, ".odata"},  128'(bus.odata),  128'(e.data));
        check({e.tag, ".ovalid"}, 128'(bus.ovalid), 128'(e.valid));
        check({e.tag, ".ovch"},   128'(bus.ovch),   128'(e.vch));
        $display("[TB] txn %0d %s odata=%0h ovalid=%0b ovch=%0h", txn, e.tag,
                 bus.odata, bus.ovalid, bus.ovch);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    ones    = '1;
    m_data  = '0;
    m_vch   = '0;
    act_clr = 1'b0;
    rst_    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.sel      = 5'b00001 << (i % 2);
      bus.idata_0  = DATAW'({$urandom(), $urandom(), $urandom()});
      bus.idata_1  = DATAW'({$urandom(), $urandom(), $urandom()});
      bus.ivalid_0 = 1'b1; bus.ivalid_1 = 1'b1;
      bus.ivch_0   = VCHW'($urandom()); bus.ivch_1 = VCHW'($urandom());
      act_clr      = $urandom() % 2 == 0;
    end
    #1 check_outputs_zero("in_reset");
    @(negedge clk);
    bus.sel = '0; bus.idata_0 = '0; bus.idata_1 = '0;
    bus.ivalid_0 = 1'b0; bus.ivalid_1 = 1'b0; bus.ivch_0 = '0; bus.ivch_1 = '0;
    act_clr = 1'b0;
    rst_ = 1'b1;
    #1 check_outputs_zero("rst_release");

    for (int i = 0; i < 20; i++)
      drive(5'b00010, {NONE, 64'hdead}, 1'b0, 2'b00,
            {DATA, 32'h0, 32'(i + 1)}, 1'b1, 2'b01, 1'b0, "p1_stream");

    drive(5'b00001, {HEAD, 32'h0, 32'h09}, 1'b1, 2'b10, {DATA, 64'h55}, 1'b1, 2'b11, 1'b0, "p0_head");
    for (int i = 0; i < 2; i++)
      drive(5'b00001, {HEAD, 32'h0, 32'h09}, 1'b1, 2'b10,
            {TAIL, 64'(i + 7)}, 1'b0, 2'b00, 1'b0, "p0_p1noise");

    drive(5'b00000, {TAIL, 64'h111}, 1'b1, 2'b01, {TAIL, 64'h222}, 1'b1, 2'b11, 1'b0, "sel_none");
    drive(5'b00011, {DATA, 64'h333}, 1'b1, 2'b00, {DATA, 64'h444}, 1'b1, 2'b01, 1'b0, "sel_both");
    drive(5'b11100, {DATA, 64'h666}, 1'b1, 2'b00, {DATA, 64'h777}, 1'b1, 2'b01, 1'b0, "sel_high");
    drive(5'b00001, {DATA, 64'h1234}, 1'b0, 2'b11, {HEAD, 64'h0}, 1'b1, 2'b00, 1'b0, "p0_novalid");

    for (int i = 0; i < 8; i++)
      drive((i % 2 == 0) ? 5'b00001 : 5'b00010,
            {HEAD, 64'(i)}, 1'b1, 2'b00,
            {TAIL, 64'(100 + i)}, (i % 3 != 0), 2'b11, 1'b0, "alternate");
    drive(5'b00000, '0, 1'b0, 2'b00, '0, 1'b0, 2'b00, 1'b0, "idle");
    drain();

`ifdef ACT_CNT_EN
    drive(5'b00001, '0,   1'b1, 2'b00, '0, 1'b0, 2'b00, 1'b1, "cnt_zero_clr");
    drive(5'b00001, ones, 1'b1, 2'b01, '0, 1'b0, 2'b00, 1'b0, "cnt_ones");
    drive(5'b00001, '0,   1'b1, 2'b01, '0, 1'b0, 2'b00, 1'b0, "cnt_zero");
    drive(5'b00000, '0,   1'b0, 2'b00, '0, 1'b0, 2'b00, 1'b0, "cnt_hold");
    @(posedge clk); #2;
    check("act_toggles", 128'(act_toggles), 128'(2 * DATAW));
    check("act_flits",   128'(act_flits),   128'd2);
    drive(5'b00001, ones, 1'b1, 2'b00, '0, 1'b0, 2'b00, 1'b1, "cnt_clr");
    @(posedge clk); #2;
    check("clr_toggles", 128'(act_toggles), 128'd0);
    check("clr_flits",   128'(act_flits),   128'd0);
    drive(5'b00000, '0, 1'b0, 2'b00, '0, 1'b0, 2'b00, 1'b0, "cnt_idle");
    drain();
`endif

    // Asynchronous reset in the middle of a cycle wipes the live output.
    drive(5'b00010, '0, 1'b0, 2'b00, {DATA, 64'habc}, 1'b1, 2'b01, 1'b0, "pre_rst");
    @(posedge clk); #2;
    rst_ = 1'b0;
    #1 check_outputs_zero("async_rst");
    bus.sel = '0;
    @(posedge clk); #1 check_outputs_zero("rst_held");
    @(negedge clk);
    rst_ = 1'b1;
    m_data = '0;
    m_vch  = '0;
    #1 check_outputs_zero("rst2_release");
    drive(5'b00000, {TAIL, 64'h5}, 1'b1, 2'b11, '0, 1'b0, 2'b00, 1'b0, "post_rst_hold");
    drive(5'b00001, {TAIL, 64'h5}, 1'b1, 2'b11, '0, 1'b0, 2'b00, 1'b0, "post_rst_load");
    drive(5'b00000, '0, 1'b0, 2'b00, '0, 1'b0, 2'b00, 1'b0, "post_rst_idle");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
